// File: rtl/edu_graphics_fpga_top.sv
// edu_graphics_fpga_top
// PCIe-style register target for the EduGraphics GPU. It decodes single-beat
// 3DW MWr/MRd TLPs and holds CTRL/status, an LED register and a 16-word
// PARAM bank. Reads are answered with a single-beat CplD held in a
// one-entry completion register.
// Build option: define EDUGPU_PARAM_READBACK_EN to make PARAM reads return
// the stored value. Without it, PARAM reads return 0, but writes are still
// stored.
module edu_graphics_fpga_top (
  input  logic         tlp_clk,
  input  logic         rst,
  input  logic         tl_rx_sop,
  input  logic         tl_rx_eop,
  input  logic [31:0]  data_7,
  input  logic [31:0]  data_6,
  input  logic [31:0]  data_5,
  input  logic [31:0]  data_4,
  input  logic [31:0]  data_3,
  input  logic [31:0]  data_2,
  input  logic [31:0]  data_1,
  input  logic [31:0]  data_0,
  input  logic         tl_tx_wait,
  output logic         tl_tx_sop,
  output logic         tl_tx_eop,
  output logic         tl_tx_valid,
  output logic [255:0] tl_tx_data,
  output logic [31:0]  pcie_tx_data,
  output logic [3:0]   led
);

  localparam logic [7:0]  FMT_MWR    = 8'h40;
  localparam logic [7:0]  FMT_MRD    = 8'h00;
  localparam logic [13:0] WADDR_LED  = 14'h3D00;  // 0xF400 as a DWORD address
  localparam logic [13:0] WADDR_CTRL = 14'h3E00;  // 0xF800 as a DWORD address
  localparam logic [31:0] CPL_DW0    = 32'h4A00_0001;
  localparam logic [31:0] CPL_DW1    = 32'h0000_0004;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Byte-lane merge: lanes whose enable is clear keep their old contents.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Header decode
  logic        w_accept;
  logic [7:0]  w_fmt;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_req_id;
  logic [7:0]  w_tag;
  logic [3:0]  w_be;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_hit_param;
  logic        w_hit_led;
  logic        w_hit_ctrl;
  logic [3:0]  w_idx;

  assign w_accept    = tl_rx_sop & tl_rx_eop;
  assign w_fmt       = data_7[31:24];
  assign w_wr        = w_accept & (w_fmt == FMT_MWR);
  assign w_rd        = w_accept & (w_fmt == FMT_MRD);
  assign w_req_id    = data_6[31:16];
  assign w_tag       = data_6[15:8];
  assign w_be        = data_6[3:0];
  assign w_addr      = data_5[15:0];
  assign w_wdata     = data_4;
  assign w_hit_param = (w_addr[15:6] == 10'h000);
  assign w_hit_led   = (w_addr[15:2] == WADDR_LED);
  assign w_hit_ctrl  = (w_addr[15:2] == WADDR_CTRL);
  assign w_idx       = w_addr[5:2];

  // Register state
  logic [15:0][31:0] r_param;
  logic [3:0]        r_led;
  logic              r_enable;
  logic              r_kick;
  logic [15:0]       r_frame_cnt;

  logic [31:0] w_param_m;
  logic [31:0] w_led_m;
  logic [31:0] w_ctrl_m;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_kick_rise;

  assign w_param_m   = be_merge(r_param[w_idx], w_wdata, w_be);
  assign w_led_m     = be_merge({28'h0, r_led}, w_wdata, w_be);
  assign w_ctrl_m    = be_merge({23'h0, r_kick, 7'h0, r_enable}, w_wdata, w_be);
  assign w_ctrl_wr   = w_wr & w_hit_ctrl;
  // The clear bit is never stored, so it acts for just the accepting cycle.
  // The old stored value feeds lane 0, so its bit 1 is always 0.
  assign w_clear     = w_ctrl_wr & w_ctrl_m[1];
  assign w_kick_rise = w_ctrl_wr & ~r_kick & w_ctrl_m[8];

  // CTRL enable/kick bits and the frame counter (counts kick 0->1 edges).
  always_ff @(posedge tlp_clk or posedge rst) begin
    if (rst) begin
      r_enable    <= 1'b0;
      r_kick      <= 1'b0;
      r_frame_cnt <= 16'h0000;
    end else if (w_ctrl_wr) begin
      r_enable <= w_ctrl_m[0];
      r_kick   <= w_ctrl_m[8];
      if (w_kick_rise) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // PARAM bank and LED register. A clear pulse takes priority over any write.
  always_ff @(posedge tlp_clk or posedge rst) begin
    if (rst) begin
      r_param <= '0;
      r_led   <= 4'h0;
    end else if (w_clear) begin
      r_param <= '0;
      r_led   <= 4'h0;
    end else begin
      if (w_wr & w_hit_param) begin
        r_param[w_idx] <= w_param_m;
      end
      if (w_wr & w_hit_led) begin
        r_led <= w_led_m[3:0];
      end
    end
  end

  // Read-data mux. It sees register contents from earlier cycles only.
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = 32'h0;
    if (w_hit_param) begin
`ifdef EDUGPU_PARAM_READBACK_EN
      w_rdata = r_param[w_idx];
`else
      w_rdata = 32'h0;
`endif
    end else if (w_hit_led) begin
      w_rdata = {28'h0, r_led};
    end else if (w_hit_ctrl) begin
      w_rdata = {r_frame_cnt, 7'h0, r_kick, 6'h0, 1'b0, r_enable};
    end
  end

  // Completion FSM: IDLE waits for an MRd; BUSY holds the beat until it transfers.
  state_t r_state;
  state_t w_state_nxt;

  // State register
  always_ff @(posedge tlp_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: the beat leaves on the first cycle without wait.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_rd) begin
        w_state_nxt = S_BUSY;
      end
    end else begin
      if (!tl_tx_wait) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Output logic: a single-beat completion carries sop, eop and valid together.
  always_comb begin
    tl_tx_valid = (r_state == S_BUSY);
    tl_tx_sop   = (r_state == S_BUSY);
    tl_tx_eop   = (r_state == S_BUSY);
  end

  // Completion register. It loads only when free; an MRd arriving while busy is dropped.
  logic         w_cpl_load;
  logic [255:0] r_tx_data;
  logic [31:0]  r_pcie_tx_data;

  assign w_cpl_load = w_rd & (r_state == S_IDLE);

  // Capture the CplD beat and its payload. The beat holds after transfer until the next load.
  always_ff @(posedge tlp_clk or posedge rst) begin
    if (rst) begin
      r_tx_data      <= '0;
      r_pcie_tx_data <= 32'h0;
    end else if (w_cpl_load) begin
      r_tx_data      <= {CPL_DW0, CPL_DW1, w_req_id, w_tag, 1'b0, w_addr[6:0],
                         w_rdata, 128'h0};
      r_pcie_tx_data <= w_rdata;
    end
  end

  assign tl_tx_data   = r_tx_data;
  assign pcie_tx_data = r_pcie_tx_data;
  assign led          = r_led;

  // Header fields and DWORDs that this target never looks at.
  logic w_unused_ok;
  assign w_unused_ok = ^{data_7[23:0], data_6[7:4], data_5[31:16],
                         data_3, data_2, data_1, data_0,
                         w_led_m[31:4], w_ctrl_m[31:9], w_ctrl_m[7:2]};

endmodule

// File: tb/tb_edu_graphics_fpga_top.sv
// Testbench for edu_graphics_fpga_top. It drives random TLP traffic and
// compares against a behavioural register-map model held in the bench.
`timescale 1ns/1ps
module tb_edu_graphics_fpga_top;

  logic         tlp_clk = 1'b0;
  logic         rst = 1'b0;
  logic         tl_rx_sop = 1'b0;
  logic         tl_rx_eop = 1'b0;
  logic [31:0]  data_7 = '0, data_6 = '0, data_5 = '0, data_4 = '0;
  logic [31:0]  data_3 = '0, data_2 = '0, data_1 = '0, data_0 = '0;
  logic         tl_tx_wait = 1'b0;
  logic         tl_tx_sop, tl_tx_eop, tl_tx_valid;
  logic [255:0] tl_tx_data;
  logic [31:0]  pcie_tx_data;
  logic [3:0]   led;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the register map
  logic [31:0] m_param [16];
  logic [3:0]  m_led;
  logic        m_en;
  logic        m_kick;
  logic [15:0] m_frame;

  edu_graphics_fpga_top dut (
    .tlp_clk(tlp_clk), .rst(rst),
    .tl_rx_sop(tl_rx_sop), .tl_rx_eop(tl_rx_eop),
    .data_7(data_7), .data_6(data_6), .data_5(data_5), .data_4(data_4),
    .data_3(data_3), .data_2(data_2), .data_1(data_1), .data_0(data_0),
    .tl_tx_wait(tl_tx_wait),
    .tl_tx_sop(tl_tx_sop), .tl_tx_eop(tl_tx_eop), .tl_tx_valid(tl_tx_valid),
    .tl_tx_data(tl_tx_data), .pcie_tx_data(pcie_tx_data), .led(led)
  );

  always #5 tlp_clk = ~tlp_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion of sequence");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    return (new_v & mask) | (old_v & ~mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    if (addr < 16'h0040) begin
`ifdef EDUGPU_PARAM_READBACK_EN
      return m_param[addr[5:2]];
`else
      return 32'h0;
`endif
    end
    if ((addr & 16'hFFFC) == 16'hF400) return {28'h0, m_led};
    if ((addr & 16'hFFFC) == 16'hF800)
      return ({16'h0, m_frame} << 16) | (m_kick ? 32'h100 : 32'h0) | {31'h0, m_en};
    return 32'h0;
  endfunction

  function automatic logic [255:0] exp_beat(input logic [15:0] rid, input logic [7:0] tag,
                                            input logic [15:0] addr, input logic [31:0] rd);
    return {32'h4A000001, 32'h00000004, rid, tag, 1'b0, addr[6:0], rd, 128'h0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_param[i] = 32'h0;
    m_led = 4'h0; m_en = 1'b0; m_kick = 1'b0; m_frame = 16'h0;
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] v;
    if (addr < 16'h0040) begin
      m_param[addr[5:2]] = lane_merge(m_param[addr[5:2]], wd, be);
    end else if ((addr & 16'hFFFC) == 16'hF400) begin
      v = lane_merge({28'h0, m_led}, wd, be);
      m_led = v[3:0];
    end else if ((addr & 16'hFFFC) == 16'hF800) begin
      v = lane_merge((m_kick ? 32'h100 : 32'h0) | {31'h0, m_en}, wd, be);
      if (v[1]) begin
        for (int i = 0; i < 16; i++) m_param[i] = 32'h0;
        m_led = 4'h0;
      end
      if (!m_kick && v[8]) m_frame = m_frame + 16'd1;
      m_kick = v[8];
      m_en   = v[0];
    end
  endtask

  // Drivers: the caller is at a falling edge; the beat is accepted on the next rising edge.
  task automatic drive(input logic [7:0] fmt, input logic [3:0] be, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [7:0] tag, input logic [15:0] rid);
    tl_rx_sop = 1'b1; tl_rx_eop = 1'b1;
    data_7 = {fmt, 24'($urandom())};
    data_6 = {rid, tag, 4'($urandom()), be};
    data_5 = {16'($urandom()), addr};
    data_4 = wd;
    data_3 = $urandom(); data_2 = $urandom(); data_1 = $urandom(); data_0 = $urandom();
  endtask

  task automatic idle();
    tl_rx_sop = 1'b0; tl_rx_eop = 1'b0;
    data_7 = $urandom(); data_6 = $urandom(); data_5 = $urandom(); data_4 = $urandom();
  endtask

  task automatic send(input logic [7:0] fmt, input logic [3:0] be, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [7:0] tag, input logic [15:0] rid);
    drive(fmt, be, addr, wd, tag, rid);
    @(negedge tlp_clk);
    idle();
  endtask

  task automatic mwr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
    send(8'h40, be, addr, wd, 8'h00, 16'h0000);
    model_write(addr, be, wd);
  endtask

  task automatic mrd(input logic [15:0] addr, input logic [7:0] tag, input logic [15:0] rid);
    send(8'h00, 4'hF, addr, $urandom(), tag, rid);
  endtask

  task automatic test_reset();
    rst = 1'b1; tl_tx_wait = 1'b0; idle(); model_reset();
    repeat (2) @(negedge tlp_clk);
    n_checks++;
    if ({tl_tx_valid, tl_tx_sop, tl_tx_eop} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {tl_tx_valid, tl_tx_sop, tl_tx_eop});
    end
    n_checks++;
    if (tl_tx_data !== 256'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", tl_tx_data); end
    n_checks++;
    if (pcie_tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_pcie: got %h expected 0", pcie_tx_data); end
    n_checks++;
    if (led !== 4'h0) begin n_fail++; $display("FAIL reset_led: got %h expected 0", led); end
    rst = 1'b0;
    @(negedge tlp_clk);
  endtask

  task automatic test_ctrl_led();
    logic [255:0] eb;
    mwr(16'hF800, 4'hF, 32'h2);
    mwr(16'hF800, 4'hF, 32'h1);
    mwr(16'hF400, 4'hF, 32'h4);
    n_checks++;
    if (led !== 4'b0100) begin n_fail++; $display("FAIL ctrl_led_value: got %b expected 0100", led); end
    eb = exp_beat(16'h1234, 8'h11, 16'hF800, model_read(16'hF800));
    mrd(16'hF800, 8'h11, 16'h1234);
    n_checks++;
    if ({tl_tx_valid, tl_tx_sop, tl_tx_eop} !== 3'b111) begin
      n_fail++; $display("FAIL ctrl_rd_flags: got %b expected 111", {tl_tx_valid, tl_tx_sop, tl_tx_eop});
    end
    n_checks++;
    if (tl_tx_data[159:128] !== 32'h00000001) begin
      n_fail++; $display("FAIL ctrl_rd_dw3: got %h expected 00000001", tl_tx_data[159:128]);
    end
    n_checks++;
    if (tl_tx_data !== eb) begin n_fail++; $display("FAIL ctrl_rd_beat: got %h expected %h", tl_tx_data, eb); end
    @(negedge tlp_clk);
    n_checks++;
    if (tl_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_rd_done: got valid %b expected 0", tl_tx_valid); end
  endtask

  task automatic test_param_rw();
    logic [31:0] ed;
`ifdef EDUGPU_PARAM_READBACK_EN
    ed = 32'h03020203;
`else
    ed = 32'h0;
`endif
    mwr(16'h0014, 4'hF, 32'h03020203);
    mrd(16'h0014, 8'h04, 16'hBEEF);
    n_checks++;
    if (tl_tx_data[255:224] !== 32'h4A000001) begin
      n_fail++; $display("FAIL param_dw0: got %h expected 4a000001", tl_tx_data[255:224]);
    end
    n_checks++;
    if (tl_tx_data[191:160] !== {16'hBEEF, 8'h04, 8'h14}) begin
      n_fail++; $display("FAIL param_dw2: got %h expected beef0414", tl_tx_data[191:160]);
    end
    n_checks++;
    if (tl_tx_data[159:128] !== ed) begin n_fail++; $display("FAIL param_dw3: got %h expected %h", tl_tx_data[159:128], ed); end
    n_checks++;
    if (pcie_tx_data !== ed) begin n_fail++; $display("FAIL param_pcie: got %h expected %h", pcie_tx_data, ed); end
    n_checks++;
    if (tl_tx_data[127:0] !== 128'h0 || tl_tx_data[223:192] !== 32'h4) begin
      n_fail++; $display("FAIL param_fixed_dw: got %h expected dw1=4, rest 0", tl_tx_data);
    end
    @(negedge tlp_clk);
  endtask

  task automatic test_frame_cnt();
    mwr(16'hF800, 4'hF, 32'h100);
    mwr(16'hF800, 4'hF, 32'h0);
    mrd(16'hF800, 8'h21, 16'h0001);
    n_checks++;
    if (tl_tx_data[159:128] !== 32'h00010000) begin
      n_fail++; $display("FAIL frame_first: got %h expected 00010000", tl_tx_data[159:128]);
    end
    @(negedge tlp_clk);
    mwr(16'hF800, 4'hF, 32'h100);
    mwr(16'hF800, 4'hF, 32'h100);
    mrd(16'hF800, 8'h22, 16'h0001);
    n_checks++;
    if (tl_tx_data[159:128] !== 32'h00020100 || model_read(16'hF800) !== 32'h00020100) begin
      n_fail++; $display("FAIL frame_repeat_kick: got %h expected 00020100", tl_tx_data[159:128]);
    end
    @(negedge tlp_clk);
  endtask

  task automatic test_back_pressure();
    logic [31:0]  ed;
    logic [255:0] eb;
    tl_tx_wait = 1'b1;
    ed = model_read(16'hF800);
    eb = exp_beat(16'h5A5A, 8'h33, 16'hF800, ed);
    mrd(16'hF800, 8'h33, 16'h5A5A);
    n_checks++;
    if (tl_tx_valid !== 1'b1 || tl_tx_data !== eb) begin
      n_fail++; $display("FAIL stall_start: got valid %b data %h expected 1 %h", tl_tx_valid, tl_tx_data, eb);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(8'h00, 4'hF, 16'h0004, 32'h0, 8'h77, 16'h7777);
      else if (i == 2) drive(8'h40, 4'hF, 16'hF400, 32'h9, 8'h00, 16'h0);
      else idle();
      @(negedge tlp_clk);
      if (i == 2) model_write(16'hF400, 4'hF, 32'h9);
      n_checks++;
      if (tl_tx_valid !== 1'b1 || tl_tx_data !== eb) begin
        n_fail++; $display("FAIL stall_hold_%0d: got valid %b data %h expected 1 %h", i, tl_tx_valid, tl_tx_data, eb);
      end
    end
    idle();
    tl_tx_wait = 1'b0;
    @(negedge tlp_clk);
    n_checks++;
    if (tl_tx_valid !== 1'b0 || tl_tx_data !== eb || pcie_tx_data !== ed) begin
      n_fail++; $display("FAIL stall_release: got valid %b data %h pcie %h expected 0 %h %h",
                         tl_tx_valid, tl_tx_data, pcie_tx_data, eb, ed);
    end
    @(negedge tlp_clk);
    n_checks++;
    if (tl_tx_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dropped_rd: got valid %b expected 0", tl_tx_valid); end
    n_checks++;
    if (led !== 4'h9) begin n_fail++; $display("FAIL stall_write_exec: got %h expected 9", led); end
    // A reset during a pending completion drops it at once.
    tl_tx_wait = 1'b1;
    mrd(16'hF400, 8'h44, 16'h4444);
    n_checks++;
    if (tl_tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got valid %b expected 1", tl_tx_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tl_tx_valid, tl_tx_sop, tl_tx_eop} !== 3'b000 || tl_tx_data !== 256'h0 || led !== 4'h0) begin
      n_fail++; $display("FAIL midrst_drop: got flags %b led %h expected 000 0", {tl_tx_valid, tl_tx_sop, tl_tx_eop}, led);
    end
    model_reset();
    @(negedge tlp_clk);
    rst = 1'b0; tl_tx_wait = 1'b0;
    @(negedge tlp_clk);
  endtask

  task automatic test_be_clear();
    logic [31:0] ed;
`ifdef EDUGPU_PARAM_READBACK_EN
    ed = 32'h0302FFFF;
`else
    ed = 32'h0;
`endif
    mwr(16'h0014, 4'hF, 32'h03020203);
    mwr(16'h0014, 4'h3, 32'hFFFFFFFF);
    mrd(16'h0014, 8'h55, 16'h0002);
    n_checks++;
    if (tl_tx_data[159:128] !== ed) begin n_fail++; $display("FAIL be_merge: got %h expected %h", tl_tx_data[159:128], ed); end
    @(negedge tlp_clk);
    mwr(16'hF400, 4'hF, 32'h5);
    mwr(16'hF800, 4'hE, 32'h2);
    n_checks++;
    if (led !== 4'h5) begin n_fail++; $display("FAIL clear_lane_off: got %h expected 5", led); end
    mwr(16'hF800, 4'h1, 32'h2);
    n_checks++;
    if (led !== 4'h0) begin n_fail++; $display("FAIL clear_led: got %h expected 0", led); end
    mrd(16'h0014, 8'h56, 16'h0002);
    n_checks++;
    if (tl_tx_data[159:128] !== 32'h0) begin n_fail++; $display("FAIL clear_param: got %h expected 0", tl_tx_data[159:128]); end
    @(negedge tlp_clk);
  endtask

  task automatic test_unmapped_bad_type();
    mrd(16'h1000, 8'h66, 16'h0003);
    n_checks++;
    if (tl_tx_valid !== 1'b1 || tl_tx_data[159:128] !== 32'h0 || pcie_tx_data !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_rd: got valid %b dw3 %h expected 1 0", tl_tx_valid, tl_tx_data[159:128]);
    end
    @(negedge tlp_clk);
    mwr(16'hF400, 4'hF, 32'h3);
    send(8'h44, 4'hF, 16'hF400, 32'hC, 8'h00, 16'h0);
    n_checks++;
    if (led !== 4'h3 || tl_tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL bad_type: got led %h valid %b expected 3 0", led, tl_tx_valid);
    end
    drive(8'h40, 4'hF, 16'hF400, 32'hA, 8'h00, 16'h0);
    tl_rx_eop = 1'b0;
    @(negedge tlp_clk);
    drive(8'h00, 4'hF, 16'hF400, 32'h0, 8'h00, 16'h0);
    tl_rx_sop = 1'b0;
    @(negedge tlp_clk);
    idle();
    n_checks++;
    if (led !== 4'h3 || tl_tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL partial_beat: got led %h valid %b expected 3 0", led, tl_tx_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0]  a;
    logic [31:0]  ed;
    logic [255:0] eb;
    logic [7:0]   tag;
    logic [15:0]  rid;
    int           stall;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: a = {10'h0, 4'($urandom()), 2'($urandom())};
        1: a = {14'h3D00, 2'($urandom())};
        2: a = {14'h3E00, 2'($urandom())};
        default: a = 16'($urandom());
      endcase
      if ($urandom_range(0, 1) == 0) begin
        mwr(a, 4'($urandom()), $urandom());
        n_checks++;
        if (led !== m_led) begin n_fail++; $display("FAIL rnd_led_%0d: got %h expected %h", it, led, m_led); end
      end else begin
        tag = 8'($urandom()); rid = 16'($urandom());
        stall = $urandom_range(0, 2);
        tl_tx_wait = (stall != 0);
        ed = model_read(a);
        eb = exp_beat(rid, tag, a, ed);
        mrd(a, tag, rid);
        n_checks++;
        if (tl_tx_valid !== 1'b1 || tl_tx_data !== eb || pcie_tx_data !== ed) begin
          n_fail++; $display("FAIL rnd_rd_%0d: got valid %b data %h expected 1 %h", it, tl_tx_valid, tl_tx_data, eb);
        end
        for (int s = 0; s < stall; s++) begin
          @(negedge tlp_clk);
          n_checks++;
          if (tl_tx_valid !== 1'b1 || tl_tx_data !== eb) begin
            n_fail++; $display("FAIL rnd_hold_%0d: got valid %b data %h expected 1 %h", it, tl_tx_valid, tl_tx_data, eb);
          end
        end
        tl_tx_wait = 1'b0;
        @(negedge tlp_clk);
        n_checks++;
        if (tl_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_done_%0d: got valid %b expected 0", it, tl_tx_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_led();
    test_param_rw();
    test_frame_cnt();
    test_back_pressure();
    test_be_clear();
    test_unmapped_bad_type();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
